wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the regfile's single write port between the in-order pipeline writeback and the long-latency multiply/divide unit. Pipeline writes always win. A long-unit result waits in a one-entry holding buffer until a free write slot appears, and the block raises a stall request if that result starves. A 32-entry pending scoreboard reports read-after-write hazards to decode for registers whose long-unit result has not yet been written. Sits between the MEM/WB stage, the long unit and the regfile write port, with hazard outputs feeding the decode stall logic.

## Interface
- `STARVE_MAX`, default 8: cycles a buffered result may wait before `stall_req` asserts; legal range 1..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset (`RstEnable` = 1).
- `wb_we`  in  1  pipeline writeback enable.
- `wb_waddr`  in  `RegAddrBus`  pipeline destination register.
- `wb_wdata`  in  `RegBus`  pipeline writeback data.
- `lu_valid`  in  1  long-unit result valid.
- `lu_waddr`  in  `RegAddrBus`  long-unit destination register.
- `lu_wdata`  in  `RegBus`  long-unit result data.
- `lu_ready`  out  1  holding buffer can accept a result.
- `iss_valid`  in  1  decode issued an instruction to the long unit this cycle.
- `iss_waddr`  in  `RegAddrBus`  destination of that instruction.
- `re1`, `re2`  in  1 each  decode read enables.
- `raddr1`, `raddr2`  in  `RegAddrBus` each  decode read addresses.
- `hazard1`, `hazard2`  out  1 each  operand belongs to a pending long-unit write.
- `rf_we`  out  1  regfile write enable.
- `rf_waddr`  out  `RegAddrBus`  regfile write address.
- `rf_wdata`  out  `RegBus`  regfile write data.
- `stall_req`  out  1  request for the pipeline to insert writeback bubbles.

## Operation
- Holding buffer registers: `buf_valid`, `buf_waddr`, `buf_wdata`.
- Handshake: `lu_ready` is the inverse of `buf_valid`. A result is accepted when `lu_valid` and `lu_ready` are both 1, and is captured at the next edge. The long unit holds its result stable until it is accepted.
- Drain: `drain` is 1 when `buf_valid` is 1 and `wb_we` is 0. `drain` clears `buf_valid` at the edge.
- Write port, combinational:
  - If `wb_we` is 1, drive the pipeline triple.
  - Else if `drain` is 1, drive the buffer triple.
  - Otherwise `rf_we` is 0.
  - Force `rf_we` to 0 whenever the selected address is 0.
- Scoreboard: 32-bit `pending` register.
  - Set bit `iss_waddr` when `iss_valid` is 1 and `iss_waddr` is not 0.
  - Clear bit `buf_waddr` when `drain` is 1.
  - If the same address is set and cleared in one cycle, set wins.
  - Bit 0 is always 0.
- Hazard: `hazard1` is 1 when `re1` is 1, `raddr1` is not 0, `pending[raddr1]` is 1, and it is not the case that (`drain` is 1 and `buf_waddr` equals `raddr1`). In that excluded case the regfile same-cycle bypass supplies the data. `hazard2` is identical using `re2` and `raddr2`.
- FSM states:
  - IDLE: buffer empty. Go to HOLD on accept.
  - HOLD: buffer full, `wait_cnt` increments each cycle `wb_we` blocks the drain. Go to IDLE on drain. Go to STARVE when `wait_cnt` reaches `STARVE_MAX`.
  - STARVE: `stall_req` is 1. Go to IDLE on drain.
- Accept and drain in the same cycle cannot occur, because `lu_ready` is 0 while `buf_valid` is 1.
- A pipeline write to the same address as the buffered result is legal. The buffered write lands later and takes effect last, since the in-order issue rules guarantee the long-unit result is younger.

## Timing
- Reset values: `buf_valid`=0, `pending`=0, state IDLE, `wait_cnt`=0. Outputs: `lu_ready`=1, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `hazard1`=0, `hazard2`=0, `stall_req`=0.
- Reset asserted mid-operation discards the buffered result and clears the scoreboard immediately. The long unit is reset by the same signal.
- Minimum latency from accept to regfile write is 1 cycle, when `wb_we` is 0 in the cycle after accept.
- `stall_req` asserts `STARVE_MAX`+1 cycles after accept under continuous `wb_we`. It deasserts in the cycle after the drain.
- `rf_*` and `hazard*` are combinational from the current inputs and state. `lu_ready` and `stall_req` are decoded from state only.

## Structure
- Reuse the shared defines `RegBus`, `RegAddrBus`, `RegNum`, `ZeroWord`, `WriteEnable` and `RstEnable`.
- Add FSM state encodings `WbaIdle`, `WbaHold` and `WbaStarve` to the shared defines file.
- One natural sub-module, `wb_scoreboard`: the pending vector plus the two hazard lookups.

## Test plan
- Idle pipeline: `lu_valid`, reg 5, data 0x1234 accepted at cycle 0 → at cycle 1 `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234; `lu_ready` back to 1 at cycle 2.
- Contention: buffer holds reg 7 while `wb_we`=1 for 3 cycles → pipeline writes pass through unchanged; reg 7 is written in the first cycle with `wb_we`=0; `stall_req` stays 0.
- Starvation with `STARVE_MAX`=4 and `wb_we` held at 1 → `stall_req`=1 from accept+5 until one cycle after the drain.
- Scoreboard: issue to reg 3, `re1`=1, `raddr1`=3 → `hazard1`=1 until the drain cycle, where `hazard1`=0 and the bypass applies; issue to reg 0 → no pending bit set and no write.
- Assert `rst` while the buffer is full with reg 9 pending → on the same cycle `lu_ready`=1, `hazard`=0, `rf_we`=0; reg 9 is never written.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared register-file defines and arbiter FSM encodings
// Purpose: widths, constants and state encodings shared by wb_port_arbiter and
//          wb_scoreboard.
// Ports:   none (package).
package wb_port_arbiter_pkg;

   localparam int RegWidth     = 32;
   localparam int RegAddrWidth = 5;
   localparam int RegNum       = 32;

   typedef logic [RegWidth-1:0]     RegBus;
   typedef logic [RegAddrWidth-1:0] RegAddrBus;

   localparam RegBus ZeroWord    = '0;
   localparam logic  WriteEnable = 1'b1;
   localparam logic  RstEnable   = 1'b1;

   typedef enum logic [1:0] {
      WbaIdle   = 2'd0,
      WbaHold   = 2'd1,
      WbaStarve = 2'd2
   } wba_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending long-unit write scoreboard with two hazard lookups
// Purpose: one bit per architectural register, set when decode issues to the
//          long unit, cleared when the buffered result drains to the regfile.
// Ports:   clk, rst           clock and asynchronous active-high reset
//          set_en, set_addr   issue of a long-unit instruction and its destination
//          clr_en, clr_addr   buffered result written to the regfile this cycle
//          re1/raddr1, re2/raddr2   decode read ports
//          hazard1, hazard2   operand still waiting on a long-unit result
module wb_scoreboard
   import wb_port_arbiter_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    set_en,
   input  logic [RegAddrWidth-1:0] set_addr,
   input  logic                    clr_en,
   input  logic [RegAddrWidth-1:0] clr_addr,
   input  logic                    re1,
   input  logic [RegAddrWidth-1:0] raddr1,
   input  logic                    re2,
   input  logic [RegAddrWidth-1:0] raddr2,
   output logic                    hazard1,
   output logic                    hazard2
);

   logic [RegNum-1:0] pending;
   logic [RegNum-1:0] pending_nxt;
   logic [RegNum-1:0] set_mask;
   logic [RegNum-1:0] clr_mask;

   // Clear is applied before set so a re-issue to the draining register keeps
   // its bit; register 0 is hardwired and never tracked.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_addr != '0)) begin
         set_mask[set_addr] = 1'b1;
      end
      if (clr_en) begin
         clr_mask[clr_addr] = 1'b1;
      end
      pending_nxt    = (pending & ~clr_mask) | set_mask;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   // A register draining this cycle is served by the regfile write-through
   // bypass, so it is not reported as a hazard.
   always_comb begin
      hazard1 = re1 && (raddr1 != '0) && pending[raddr1]
                && !(clr_en && (clr_addr == raddr1));
      hazard2 = re2 && (raddr2 != '0) && pending[raddr2]
                && !(clr_en && (clr_addr == raddr2));
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - regfile write-port arbiter between pipeline writeback and long unit
// Purpose: pipeline writeback always owns the write port; a long-unit result
//          waits in a one-entry buffer for a free slot and requests writeback
//          bubbles once it has waited STARVE_MAX blocked cycles.
// Ports:   clk, rst                      clock and asynchronous active-high reset
//          wb_we/wb_waddr/wb_wdata       pipeline writeback triple
//          lu_valid/lu_waddr/lu_wdata    long-unit result, lu_ready accepts it
//          iss_valid/iss_waddr           long-unit issue from decode
//          re1/raddr1, re2/raddr2        decode reads, hazard1/hazard2 replies
//          rf_we/rf_waddr/rf_wdata       regfile write port
//          stall_req                     ask pipeline for writeback bubbles
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 8
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wb_we,
   input  logic [RegAddrWidth-1:0] wb_waddr,
   input  logic [RegWidth-1:0]     wb_wdata,
   input  logic                    lu_valid,
   input  logic [RegAddrWidth-1:0] lu_waddr,
   input  logic [RegWidth-1:0]     lu_wdata,
   output logic                    lu_ready,
   input  logic                    iss_valid,
   input  logic [RegAddrWidth-1:0] iss_waddr,
   input  logic                    re1,
   input  logic [RegAddrWidth-1:0] raddr1,
   input  logic                    re2,
   input  logic [RegAddrWidth-1:0] raddr2,
   output logic                    hazard1,
   output logic                    hazard2,
   output logic                    rf_we,
   output logic [RegAddrWidth-1:0] rf_waddr,
   output logic [RegWidth-1:0]     rf_wdata,
   output logic                    stall_req
);

   wba_state_t state;
   wba_state_t state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;
   logic [8:0] wait_inc;

   logic       buf_valid;
   RegAddrBus  buf_waddr;
   RegBus      buf_wdata;

   logic       accept;
   logic       drain;

   assign lu_ready  = (state == WbaIdle);
   assign stall_req = (state == WbaStarve);
   assign accept    = lu_valid && lu_ready;
   assign drain     = buf_valid && !wb_we;
   assign wait_inc  = {1'b0, wait_cnt} + 9'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         buf_valid <= 1'b0;
         buf_waddr <= '0;
         buf_wdata <= ZeroWord;
      end else if (accept) begin
         buf_valid <= 1'b1;
         buf_waddr <= lu_waddr;
         buf_wdata <= lu_wdata;
      end else if (drain) begin
         buf_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state    <= WbaIdle;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Starvation is declared on the edge where the blocked-cycle count reaches
   // STARVE_MAX, so stall_req appears STARVE_MAX+1 cycles after accept.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         WbaIdle: begin
            if (accept) begin
               state_nxt = WbaHold;
               wait_nxt  = '0;
            end
         end
         WbaHold: begin
            if (drain) begin
               state_nxt = WbaIdle;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_inc[7:0];
               if (wait_inc >= 9'(STARVE_MAX)) begin
                  state_nxt = WbaStarve;
               end
            end
         end
         WbaStarve: begin
            if (drain) begin
               state_nxt = WbaIdle;
               wait_nxt  = '0;
            end
         end
         default: begin
            state_nxt = WbaIdle;
            wait_nxt  = '0;
         end
      endcase
   end

   // Register 0 is never written even when its triple is selected.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = ZeroWord;
      if (wb_we) begin
         rf_waddr = wb_waddr;
         rf_wdata = wb_wdata;
         rf_we    = (wb_waddr != '0) ? WriteEnable : 1'b0;
      end else if (drain) begin
         rf_waddr = buf_waddr;
         rf_wdata = buf_wdata;
         rf_we    = (buf_waddr != '0) ? WriteEnable : 1'b0;
      end
   end

   wb_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_en   (iss_valid),
      .set_addr (iss_waddr),
      .clr_en   (drain),
      .clr_addr (buf_waddr),
      .re1      (re1),
      .raddr1   (raddr1),
      .re2      (re2),
      .raddr2   (raddr2),
      .hazard1  (hazard1),
      .hazard2  (hazard2)
   );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed vector bench for wb_port_arbiter
module tb_wb_port_arbiter;

   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_waddr;
      logic [31:0] wb_wdata;
      logic        lu_valid;
      logic [4:0]  lu_waddr;
      logic [31:0] lu_wdata;
      logic        iss_valid;
      logic [4:0]  iss_waddr;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic [41:0] expect_out;
   } vec_t;

   localparam int NVEC = 25;

   logic        clk;
   logic        rst;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        lu_valid;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic        iss_valid;
   logic [4:0]  iss_waddr;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;
   logic        hazard1;
   logic        hazard2;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;

   int   n_vec;
   int   n_mis;
   vec_t vecs[NVEC];

   wb_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_we     (wb_we),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .lu_valid  (lu_valid),
      .lu_waddr  (lu_waddr),
      .lu_wdata  (lu_wdata),
      .lu_ready  (lu_ready),
      .iss_valid (iss_valid),
      .iss_waddr (iss_waddr),
      .re1       (re1),
      .raddr1    (raddr1),
      .re2       (re2),
      .raddr2    (raddr2),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .stall_req (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input int unsigned w_we, input int unsigned w_a, input int unsigned w_d,
      input int unsigned l_v, input int unsigned l_a, input int unsigned l_d,
      input int unsigned i_v, input int unsigned i_a,
      input int unsigned r1, input int unsigned a1,
      input int unsigned r2, input int unsigned a2,
      input int unsigned e_rdy, input int unsigned e_we, input int unsigned e_a,
      input int unsigned e_d, input int unsigned e_h1, input int unsigned e_h2,
      input int unsigned e_st);
      vec_t v;
      v.wb_we      = w_we[0];
      v.wb_waddr   = w_a[4:0];
      v.wb_wdata   = w_d;
      v.lu_valid   = l_v[0];
      v.lu_waddr   = l_a[4:0];
      v.lu_wdata   = l_d;
      v.iss_valid  = i_v[0];
      v.iss_waddr  = i_a[4:0];
      v.re1        = r1[0];
      v.raddr1     = a1[4:0];
      v.re2        = r2[0];
      v.raddr2     = a2[4:0];
      v.expect_out = {e_rdy[0], e_we[0], e_a[4:0], e_d, e_h1[0], e_h2[0], e_st[0]};
      return v;
   endfunction

   function automatic logic [41:0] actual_out();
      return {lu_ready, rf_we, rf_waddr, rf_wdata, hazard1, hazard2, stall_req};
   endfunction

   task automatic clear_inputs();
      wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
      iss_valid = 1'b0; iss_waddr = '0;
      re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
   endtask

   task automatic apply(input vec_t v);
      wb_we = v.wb_we; wb_waddr = v.wb_waddr; wb_wdata = v.wb_wdata;
      lu_valid = v.lu_valid; lu_waddr = v.lu_waddr; lu_wdata = v.lu_wdata;
      iss_valid = v.iss_valid; iss_waddr = v.iss_waddr;
      re1 = v.re1; raddr1 = v.raddr1; re2 = v.re2; raddr2 = v.raddr2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_mis = 0;
      clear_inputs();
      rst = 1'b1;

      //            we wa wd       lv la ld        iv ia  r1 a1  r2 a2 | rdy we wa wd       h1 h2 st
      vecs[0]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[1]  = mk(1, 4, 'hAAAA,  0, 0, 0,        0, 0,  0, 0,  0, 0,   1, 1, 4, 'hAAAA,   0, 0, 0);
      vecs[2]  = mk(1, 0, 'h55,    0, 0, 0,        0, 0,  0, 0,  0, 0,   1, 0, 0, 'h55,     0, 0, 0);
      vecs[3]  = mk(0, 0, 0,       1, 5, 'h1234,   0, 0,  0, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[4]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  0, 0,   0, 1, 5, 'h1234,   0, 0, 0);
      vecs[5]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[6]  = mk(0, 0, 0,       0, 0, 0,        1, 3,  1, 3,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[7]  = mk(1, 8, 'h88,    1, 3, 'h33,     0, 0,  1, 3,  0, 0,   1, 1, 8, 'h88,     1, 0, 0);
      vecs[8]  = mk(1, 8, 'h99,    0, 0, 0,        0, 0,  1, 3,  1, 3,   0, 1, 8, 'h99,     1, 1, 0);
      vecs[9]  = mk(0, 0, 0,       0, 0, 0,        0, 0,  1, 3,  0, 3,   0, 1, 3, 'h33,     0, 0, 0);
      vecs[10] = mk(0, 0, 0,       0, 0, 0,        0, 0,  1, 3,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[11] = mk(0, 0, 0,       0, 0, 0,        1, 0,  1, 0,  1, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[12] = mk(0, 0, 0,       0, 0, 0,        0, 0,  1, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[13] = mk(0, 0, 0,       1, 12, 'hC0,    1, 12, 0, 0,  1, 12,  1, 0, 0, 0,        0, 0, 0);
      vecs[14] = mk(0, 0, 0,       0, 0, 0,        1, 12, 0, 0,  1, 12,  0, 1, 12, 'hC0,    0, 0, 0);
      vecs[15] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  1, 12,  1, 0, 0, 0,        0, 1, 0);
      vecs[16] = mk(0, 0, 0,       1, 12, 'hC1,    0, 0,  0, 0,  1, 12,  1, 0, 0, 0,        0, 1, 0);
      vecs[17] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  1, 12,  0, 1, 12, 'hC1,    0, 0, 0);
      vecs[18] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  1, 12,  1, 0, 0, 0,        0, 0, 0);
      vecs[19] = mk(0, 0, 0,       1, 7, 'h77,     0, 0,  0, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);
      vecs[20] = mk(1, 1, 'h101,   0, 0, 0,        0, 0,  0, 0,  0, 0,   0, 1, 1, 'h101,    0, 0, 0);
      vecs[21] = mk(1, 2, 'h202,   0, 0, 0,        0, 0,  0, 0,  0, 0,   0, 1, 2, 'h202,    0, 0, 0);
      vecs[22] = mk(1, 0, 'h303,   0, 0, 0,        0, 0,  0, 0,  0, 0,   0, 0, 0, 'h303,    0, 0, 0);
      vecs[23] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  0, 0,   0, 1, 7, 'h77,     0, 0, 0);
      vecs[24] = mk(0, 0, 0,       0, 0, 0,        0, 0,  0, 0,  0, 0,   1, 0, 0, 0,        0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         apply(vecs[i]);
         @(negedge clk);
         n_vec++;
         if (actual_out() !== vecs[i].expect_out) begin
            n_mis++;
            $display("FAIL vec%0d {rdy,we,waddr,wdata,h1,h2,stall}: got %h expected %h",
                     i, actual_out(), vecs[i].expect_out);
         end
      end

      // Starvation with STARVE_MAX=4 under continuous pipeline writes.
      @(posedge clk); #1;
      clear_inputs();
      lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA0;
      wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'h11;
      @(negedge clk);
      chk("starve_accept_ready", 32'(lu_ready), 32'd1);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk); #1;
         lu_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("starve_stall_c%0d", c), 32'(stall_req), (c >= 5) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      wb_we = 1'b0;
      @(negedge clk);
      chk("starve_drain_stall", 32'(stall_req), 32'd1);
      chk("starve_drain_write", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd10});
      chk("starve_drain_data", rf_wdata, 32'hA0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("starve_after_stall", 32'(stall_req), 32'd0);
      chk("starve_after_ready", 32'(lu_ready), 32'd1);

      // Reset while the buffer holds a pending result for reg 9.
      @(posedge clk); #1;
      clear_inputs();
      iss_valid = 1'b1; iss_waddr = 5'd9;
      @(posedge clk); #1;
      iss_valid = 1'b0;
      lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
      re1 = 1'b1; raddr1 = 5'd9;
      @(negedge clk);
      chk("rst_pre_hazard", 32'(hazard1), 32'd1);
      @(posedge clk); #1;
      lu_valid = 1'b0;
      wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h22;
      #1;
      chk("rst_pre_full", 32'(lu_ready), 32'd0);
      #1;
      rst = 1'b1;
      wb_we = 1'b0;
      #1;
      chk("rst_now_ready", 32'(lu_ready), 32'd1);
      chk("rst_now_hazard", 32'(hazard1), 32'd0);
      chk("rst_now_we", 32'(rf_we), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("rst_after_we_c%0d", c), 32'(rf_we), 32'd0);
         chk($sformatf("rst_after_hazard_c%0d", c), 32'(hazard1), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
